// File: rtl/regfile_mp_pkg.sv
// Shared types and constants for the multi-port register file.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
package regfile_mp_pkg;

  typedef enum logic {
    RF_INIT = 1'b0,
    RF_RUN  = 1'b1
  } rf_state_e;

  localparam logic RST_ENABLE   = 1'b0;
  localparam logic WRITE_ENABLE = 1'b1;
  localparam logic READ_ENABLE  = 1'b1;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write port bundle between the pipeline (master) and the register file (slave).
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);
  logic                                clr;
  logic                                ready;
  logic [NWRITE-1:0]                   we;
  logic [NWRITE-1:0][ADDR_W-1:0]       waddr;
  logic [NWRITE-1:0][DATA_W-1:0]       wdata;
  logic [NREAD-1:0]                    re;
  logic [NREAD-1:0][ADDR_W-1:0]        raddr;
  logic [NREAD-1:0][DATA_W-1:0]        rdata;

  modport master (output clr, we, waddr, wdata, re, raddr, input  ready, rdata);
  modport slave  (input  clr, we, waddr, wdata, re, raddr, output ready, rdata);
endinterface

// File: rtl/regfile_mp_rport.sv
// One combinational read port: zero gating, then optional forwarding, then stored data.
module regfile_mp_rport
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NWRITE = 1
) (
  input  logic                          rst,
  input  logic                          run,
  input  logic                          re,
  input  logic [ADDR_W-1:0]             raddr,
  input  logic [DATA_W-1:0]             store,
  input  logic [NWRITE-1:0]             we,
  input  logic [NWRITE-1:0][ADDR_W-1:0] waddr,
  input  logic [NWRITE-1:0][DATA_W-1:0] wdata,
  output logic [DATA_W-1:0]             rdata
);

  logic              byp_hit;
  logic [DATA_W-1:0] byp_data;

  // Ascending scan so the highest-index matching port wins, same as write priority.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    for (int k = 0; k < NWRITE; k++) begin
      if (we[k] == WRITE_ENABLE && waddr[k] == raddr) begin
        byp_hit  = 1'b1;
        byp_data = wdata[k];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (rst != RST_ENABLE && run && raddr != '0 && re == READ_ENABLE)
      rdata = (BYPASS_EN && byp_hit) ? byp_data : store;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with r0 hardwired to zero and a hardware scrub after reset/clr.
// Build option: REGFILE_BYPASS_EN forwards same-cycle write data to matching reads.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input  logic         clk,
  input  logic         rst,
  regfile_mp_if.slave  bus
);

  localparam int              DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = '1;

  rf_state_e                     state_q, state_d;
  logic [ADDR_W-1:0]             cnt_q, cnt_d;
  logic [DATA_W-1:0]             regs_q [DEPTH];
  logic [DATA_W-1:0]             regs_d [DEPTH];
  logic [NREAD-1:0][DATA_W-1:0]  rd_store;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (bus.clr) begin
      state_d = RF_INIT;
      cnt_d   = ADDR_W'(1);
    end else if (state_q == RF_INIT) begin
      cnt_d = cnt_q + ADDR_W'(1);
      if (cnt_q == LAST) begin
        state_d = RF_RUN;
        cnt_d   = ADDR_W'(1);
      end
    end
  end

  // clr discards both scrub and pipeline writes; later ports overwrite earlier ones on a clash.
  always_comb begin
    regs_d = regs_q;
    if (!bus.clr) begin
      if (state_q == RF_INIT) begin
        regs_d[cnt_q] = '0;
      end else begin
        for (int k = 0; k < NWRITE; k++)
          if (bus.we[k] == WRITE_ENABLE && bus.waddr[k] != '0)
            regs_d[bus.waddr[k]] = bus.wdata[k];
      end
    end
    regs_d[0] = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RF_INIT;
      cnt_q   <= ADDR_W'(1);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) regs_q <= regs_d;

  assign bus.ready = (state_q == RF_RUN);

  for (genvar j = 0; j < NREAD; j++) begin : g_rport
    assign rd_store[j] = regs_q[bus.raddr[j]];
    regfile_mp_rport #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NWRITE(NWRITE)) u_rport (
      .rst   (rst),
      .run   (state_q == RF_RUN),
      .re    (bus.re[j]),
      .raddr (bus.raddr[j]),
      .store (rd_store[j]),
      .we    (bus.we),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .rdata (bus.rdata[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp with two read and two write ports; expectations follow
// the build (REGFILE_BYPASS_EN defined or not).
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) bus ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .NWRITE(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ready must stay low for 30 edges and rise on the 31st.
  task automatic scrub_wait(input string tag);
    for (int e = 1; e <= 31; e++) begin
      tick();
      chk(tag, {31'b0, bus.ready}, (e == 31) ? 32'd1 : 32'd0);
    end
  endtask

  initial begin
    rst = 1'b0;
    bus.clr = 1'b0;
    bus.we = '0;
    bus.waddr = '0;
    bus.wdata = '0;
    bus.re = 2'b11;
    bus.raddr[0] = 5'd5;
    bus.raddr[1] = 5'd31;
    #12;
    chk("rst_ready", {31'b0, bus.ready}, 32'd0);
    chk("rst_rd0", bus.rdata[0], 32'd0);
    chk("rst_rd1", bus.rdata[1], 32'd0);

    @(negedge clk) rst = 1'b1;
    scrub_wait("boot_ready");

    for (int a = 1; a < 32; a++) begin
      bus.raddr[0] = 5'(a);
      bus.raddr[1] = 5'(a);
      #1;
      chk("sweep_rd0", bus.rdata[0], 32'd0);
      chk("sweep_rd1", bus.rdata[1], 32'd0);
    end

    // basic write then read on both ports
    bus.we = 2'b01; bus.waddr[0] = 5'd5; bus.wdata[0] = 32'hDEADBEEF;
    tick();
    bus.we = '0; bus.raddr[0] = 5'd5; bus.raddr[1] = 5'd5;
    #1;
    chk("r5_rd0", bus.rdata[0], 32'hDEADBEEF);
    chk("r5_rd1", bus.rdata[1], 32'hDEADBEEF);

    // r0 is never written and never forwarded
    bus.we = 2'b01; bus.waddr[0] = 5'd0; bus.wdata[0] = 32'hFFFFFFFF; bus.raddr[0] = 5'd0;
    #1;
    chk("r0_same", bus.rdata[0], 32'd0);
    tick();
    bus.we = '0;
    #1;
    chk("r0_after", bus.rdata[0], 32'd0);

    // write clash on r7: port 1 wins
    bus.we = 2'b11; bus.waddr[0] = 5'd7; bus.waddr[1] = 5'd7;
    bus.wdata[0] = 32'h11111111; bus.wdata[1] = 32'h22222222; bus.raddr[1] = 5'd7;
    #1;
    chk("clash_same", bus.rdata[1], BYP ? 32'h22222222 : 32'd0);
    tick();
    bus.we = '0; bus.raddr[0] = 5'd7;
    #1;
    chk("clash_rd0", bus.rdata[0], 32'h22222222);
    chk("clash_rd1", bus.rdata[1], 32'h22222222);

    // same-cycle write/read of r9
    bus.we = 2'b01; bus.waddr[0] = 5'd9; bus.wdata[0] = 32'hCAFE0001; bus.raddr[0] = 5'd9;
    #1;
    chk("byp_same", bus.rdata[0], BYP ? 32'hCAFE0001 : 32'd0);
    tick();
    bus.we = '0;
    #1;
    chk("byp_next", bus.rdata[0], 32'hCAFE0001);

    // read enable gating
    bus.re = 2'b10; bus.raddr[0] = 5'd5; bus.raddr[1] = 5'd5;
    #1;
    chk("re_off", bus.rdata[0], 32'd0);
    chk("re_on", bus.rdata[1], 32'hDEADBEEF);
    bus.re = 2'b11;

    // clr pulse with r3 = 5; writes during the scrub must be dropped
    bus.we = 2'b01; bus.waddr[0] = 5'd3; bus.wdata[0] = 32'h5;
    tick();
    bus.we = '0; bus.raddr[0] = 5'd3;
    #1;
    chk("r3_set", bus.rdata[0], 32'h5);
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_ready", {31'b0, bus.ready}, 32'd0);
    bus.we = 2'b01; bus.waddr[0] = 5'd3; bus.wdata[0] = 32'hABCD;
    #1;
    chk("init_rd", bus.rdata[0], 32'd0);
    scrub_wait("clr_scrub");
    bus.we = '0;
    #1;
    chk("r3_clr", bus.rdata[0], 32'd0);
    chk("r5_clr", bus.rdata[1], 32'd0);

    // clr on the last scrub edge restarts the scrub
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    for (int e = 1; e <= 30; e++) tick();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_last", {31'b0, bus.ready}, 32'd0);
    scrub_wait("clr_last_scrub");

    // reset in RUN forces reads to zero immediately
    bus.we = 2'b01; bus.waddr[0] = 5'd9; bus.wdata[0] = 32'hCAFE0001; bus.raddr[0] = 5'd9;
    tick();
    bus.we = '0;
    #1;
    chk("r9_run", bus.rdata[0], 32'hCAFE0001);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_run_rd", bus.rdata[0], 32'd0);
    chk("rst_run_ready", {31'b0, bus.ready}, 32'd0);

    // reset on the 10th scrub edge, then a full restart
    @(negedge clk) rst = 1'b1;
    for (int e = 1; e <= 9; e++) tick();
    @(negedge clk) rst = 1'b0;
    tick();
    chk("rst_mid_ready", {31'b0, bus.ready}, 32'd0);
    @(negedge clk) rst = 1'b1;
    scrub_wait("rst_mid_scrub");
    chk("r9_scrubbed", bus.rdata[0], 32'd0);

    // write port 1 alone
    bus.we = 2'b10; bus.waddr[1] = 5'd12; bus.wdata[1] = 32'h12345678;
    tick();
    bus.we = '0; bus.raddr[1] = 5'd12;
    #1;
    chk("p1_write", bus.rdata[1], 32'h12345678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
